// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo issue stage: class encoding, ROB entry and register status.
// Storage widths below follow the default geometry; instantiations must not exceed them.
package tomasulo_pkg;

    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_FUNC_W    = 4;
    localparam int DEF_ROB_DEPTH = 8;

    localparam int PKG_REG_W  = $clog2(DEF_NUM_REGS);
    localparam int PKG_FUNC_W = DEF_FUNC_W;
    localparam int PKG_TAG_W  = $clog2(DEF_ROB_DEPTH);

    typedef enum logic [2:0] {
        CLS_ADD = 3'b001,
        CLS_MUL = 3'b010,
        CLS_BR  = 3'b100
    } iss_class_e;

    // Opcode bits [3:2]: 00/01 add, 10 mul, 11 branch.
    function automatic iss_class_e decode_class(input logic [1:0] op_hi);
        case (op_hi)
            2'b10:   return CLS_MUL;
            2'b11:   return CLS_BR;
            default: return CLS_ADD;
        endcase
    endfunction

    typedef struct packed {
        logic [PKG_FUNC_W-1:0] func;
        logic [PKG_REG_W-1:0]  rd;
        logic                  done;
    } rob_entry_t;

    typedef struct packed {
        logic                 busy;
        logic [PKG_TAG_W-1:0] tag;
    } reg_status_t;

endpackage

// File: rtl/rob_alloc.sv
// Reorder-buffer allocator: wrap-bit head/tail pointers, occupancy and per-entry done bits.
module rob_alloc
    import tomasulo_pkg::*;
#(
    parameter int ROB_DEPTH = DEF_ROB_DEPTH,
    localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 alloc_i,
    input  rob_entry_t           alloc_entry_i,
    input  logic                 commit_i,
    input  logic                 cdb_valid_i,
    input  logic [TAG_W-1:0]     cdb_tag_i,
    input  logic                 flush_i,
    output logic                 full_o,
    output logic                 commit_fire_o,
    output logic [TAG_W:0]       count_o,
    output logic [TAG_W-1:0]     head_tag_o,
    output logic [TAG_W-1:0]     tail_tag_o,
    output logic [PKG_REG_W-1:0] head_rd_o,
    output logic [ROB_DEPTH-1:0] done_o
);

    localparam logic [TAG_W:0] PTR_ONE = 1;

    logic [TAG_W:0] head_q, head_d;
    logic [TAG_W:0] tail_q, tail_d;
    rob_entry_t     rob_q [ROB_DEPTH];
    rob_entry_t     rob_d [ROB_DEPTH];
    logic           empty;

    assign empty         = (head_q == tail_q);
    assign full_o        = (head_q[TAG_W-1:0] == tail_q[TAG_W-1:0]) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign count_o       = tail_q - head_q;
    assign commit_fire_o = commit_i && !empty;
    assign head_tag_o    = head_q[TAG_W-1:0];
    assign tail_tag_o    = tail_q[TAG_W-1:0];
    assign head_rd_o     = rob_q[head_tag_o].rd;

    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            done_o[i] = rob_q[i].done;
        end
    end

    // Flush overrides everything; a fresh allocation clears done after any CDB write.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        rob_d  = rob_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_d[i].done = 1'b0;
            end
        end else begin
            if (commit_fire_o) begin
                head_d = head_q + PTR_ONE;
            end
            if (cdb_valid_i) begin
                rob_d[cdb_tag_i].done = 1'b1;
            end
            if (alloc_i) begin
                rob_d[tail_tag_o]      = alloc_entry_i;
                rob_d[tail_tag_o].done = 1'b0;
                tail_d                 = tail_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            rob_q  <= rob_d;
        end
    end

endmodule

// File: rtl/issue_unit.sv
// In-order issue stage: ROB tag allocation, destination renaming and a registered dispatch packet.
// Optional same-cycle CDB wakeup of source operands: define ISSUE_CDB_BYPASS_EN.
module issue_unit
    import tomasulo_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int FUNC_W    = DEF_FUNC_W,
    parameter int ROB_DEPTH = DEF_ROB_DEPTH,
    localparam int REG_W    = $clog2(NUM_REGS),
    localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [2:0]        rs_avail,
    output logic              disp_valid,
    output logic [2:0]        disp_class,
    output logic [FUNC_W-1:0] disp_func,
    output logic [TAG_W-1:0]  disp_tag,
    output logic [TAG_W-1:0]  disp_src1_tag,
    output logic [TAG_W-1:0]  disp_src2_tag,
    output logic              disp_src1_rdy,
    output logic              disp_src2_rdy,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    input  logic              flush,
    output logic [TAG_W:0]    rob_count
);

    iss_class_e           in_class;
    logic                 is_branch;
    logic                 rob_full;
    logic                 accept;
    logic                 commit_fire;
    logic [TAG_W-1:0]     tail_tag;
    logic [PKG_REG_W-1:0] head_rd;
    logic [REG_W-1:0]     head_rd_idx;
    logic [ROB_DEPTH-1:0] done;
    rob_entry_t           alloc_entry;

    reg_status_t status_q [NUM_REGS];
    reg_status_t status_d [NUM_REGS];
    reg_status_t src1, src2;
    logic [TAG_W-1:0] src1_tag, src2_tag;
    logic             src1_rdy, src2_rdy;

    logic              disp_valid_q;
    logic [2:0]        disp_class_q;
    logic [FUNC_W-1:0] disp_func_q;
    logic [TAG_W-1:0]  disp_tag_q, disp_src1_tag_q, disp_src2_tag_q;
    logic              disp_src1_rdy_q, disp_src2_rdy_q;

    assign in_class    = decode_class(in_func[3:2]);
    assign is_branch   = (in_class == CLS_BR);
    assign in_ready    = !rob_full && (|(rs_avail & in_class)) && !flush;
    assign accept      = in_valid && in_ready;
    assign head_rd_idx = REG_W'(head_rd);
    assign alloc_entry = '{func: PKG_FUNC_W'(in_func), rd: PKG_REG_W'(in_rd), done: 1'b0};

    rob_alloc #(.ROB_DEPTH(ROB_DEPTH)) u_rob (
        .clk1          (clk1),
        .rst_n         (rst_n),
        .alloc_i       (accept),
        .alloc_entry_i (alloc_entry),
        .commit_i      (commit_valid),
        .cdb_valid_i   (cdb_valid),
        .cdb_tag_i     (cdb_tag),
        .flush_i       (flush),
        .full_o        (rob_full),
        .commit_fire_o (commit_fire),
        .count_o       (rob_count),
        .head_tag_o    (commit_tag),
        .tail_tag_o    (tail_tag),
        .head_rd_o     (head_rd),
        .done_o        (done)
    );

    // Sources read the table as it stood before this instruction renames its destination.
    always_comb begin
        src1     = status_q[in_rs1];
        src2     = status_q[in_rs2];
        src1_tag = src1.busy ? TAG_W'(src1.tag) : '0;
        src2_tag = src2.busy ? TAG_W'(src2.tag) : '0;
        src1_rdy = !src1.busy || done[src1_tag];
        src2_rdy = !src2.busy || done[src2_tag];
`ifdef ISSUE_CDB_BYPASS_EN
        if (cdb_valid && src1.busy && (cdb_tag == src1_tag)) src1_rdy = 1'b1;
        if (cdb_valid && src2.busy && (cdb_tag == src2_tag)) src2_rdy = 1'b1;
`endif
    end

    // Commit clears only if the retiring entry is still the newest producer; a rename wins.
    always_comb begin
        status_d = status_q;
        if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                status_d[i].busy = 1'b0;
            end
        end else begin
            if (commit_fire && status_q[head_rd_idx].busy &&
                (TAG_W'(status_q[head_rd_idx].tag) == commit_tag)) begin
                status_d[head_rd_idx].busy = 1'b0;
            end
            if (accept && !is_branch) begin
                status_d[in_rd] = '{busy: 1'b1, tag: PKG_TAG_W'(tail_tag)};
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                status_q[i] <= '0;
            end
        end else begin
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            disp_valid_q    <= 1'b0;
            disp_class_q    <= '0;
            disp_func_q     <= '0;
            disp_tag_q      <= '0;
            disp_src1_tag_q <= '0;
            disp_src2_tag_q <= '0;
            disp_src1_rdy_q <= 1'b0;
            disp_src2_rdy_q <= 1'b0;
        end else begin
            disp_valid_q <= accept;
            if (accept) begin
                disp_class_q    <= in_class;
                disp_func_q     <= in_func;
                disp_tag_q      <= tail_tag;
                disp_src1_tag_q <= src1_tag;
                disp_src2_tag_q <= src2_tag;
                disp_src1_rdy_q <= src1_rdy;
                disp_src2_rdy_q <= src2_rdy;
            end
        end
    end

    assign disp_valid    = disp_valid_q;
    assign disp_class    = disp_class_q;
    assign disp_func     = disp_func_q;
    assign disp_tag      = disp_tag_q;
    assign disp_src1_tag = disp_src1_tag_q;
    assign disp_src2_tag = disp_src2_tag_q;
    assign disp_src1_rdy = disp_src1_rdy_q;
    assign disp_src2_rdy = disp_src2_rdy_q;

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard bench for issue_unit: directed issue/commit/flush vectors with hand-computed packets.
// Same-cycle CDB expectation follows ISSUE_CDB_BYPASS_EN.
module tb_issue_unit;

`ifdef ISSUE_CDB_BYPASS_EN
    localparam logic BYPASS_RDY = 1'b1;
`else
    localparam logic BYPASS_RDY = 1'b0;
`endif

    logic       clk1 = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_func = '0;
    logic [3:0] in_rs1 = '0;
    logic [3:0] in_rs2 = '0;
    logic [3:0] in_rd = '0;
    logic [2:0] rs_avail = 3'b111;
    logic       disp_valid;
    logic [2:0] disp_class;
    logic [3:0] disp_func;
    logic [2:0] disp_tag;
    logic [2:0] disp_src1_tag;
    logic [2:0] disp_src2_tag;
    logic       disp_src1_rdy;
    logic       disp_src2_rdy;
    logic       cdb_valid = 1'b0;
    logic [2:0] cdb_tag = '0;
    logic       commit_valid = 1'b0;
    logic [2:0] commit_tag;
    logic       flush = 1'b0;
    logic [3:0] rob_count;

    issue_unit dut (
        .clk1          (clk1),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_func       (in_func),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .rs_avail      (rs_avail),
        .disp_valid    (disp_valid),
        .disp_class    (disp_class),
        .disp_func     (disp_func),
        .disp_tag      (disp_tag),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_tag (disp_src2_tag),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .commit_valid  (commit_valid),
        .commit_tag    (commit_tag),
        .flush         (flush),
        .rob_count     (rob_count)
    );

    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic [2:0] cls;
        logic [3:0] func;
        logic [2:0] tag;
        logic [2:0] s1Tag;
        logic [2:0] s2Tag;
        logic       s1Rdy;
        logic       s2Rdy;
    } pkt_t;

    pkt_t expQ[$];
    pkt_t gotPkt;
    pkt_t wantPkt;
    int   checks = 0;
    int   failures = 0;
    int   pktNum = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveIdle();
        in_valid     = 1'b0;
        in_func      = '0;
        in_rs1       = '0;
        in_rs2       = '0;
        in_rd        = '0;
        cdb_valid    = 1'b0;
        cdb_tag      = '0;
        commit_valid = 1'b0;
        flush        = 1'b0;
    endtask

    // Drive one cycle of inputs starting just after a falling edge, then return to idle.
    task automatic applyStimulus(input logic v, input logic [3:0] func, input logic [3:0] rs1,
                                 input logic [3:0] rs2, input logic [3:0] rd, input logic cdbV,
                                 input logic [2:0] cdbT, input logic cmt, input logic fl);
        in_valid     = v;
        in_func      = func;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_rd        = rd;
        cdb_valid    = cdbV;
        cdb_tag      = cdbT;
        commit_valid = cmt;
        flush        = fl;
        @(negedge clk1);
        driveIdle();
    endtask

    task automatic issueOp(input logic [3:0] func, input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic [3:0] rd, input logic [2:0] cls, input logic [2:0] tag,
                           input logic [2:0] s1Tag, input logic [2:0] s2Tag,
                           input logic s1Rdy, input logic s2Rdy);
        expQ.push_back('{cls: cls, func: func, tag: tag, s1Tag: s1Tag, s2Tag: s2Tag,
                         s1Rdy: s1Rdy, s2Rdy: s2Rdy});
        applyStimulus(1'b1, func, rs1, rs2, rd, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    // Monitor: every dispatch pulse must match the oldest outstanding expectation.
    always @(negedge clk1) begin
        if (rst_n && disp_valid) begin
            gotPkt = '{cls: disp_class, func: disp_func, tag: disp_tag, s1Tag: disp_src1_tag,
                       s2Tag: disp_src2_tag, s1Rdy: disp_src1_rdy, s2Rdy: disp_src2_rdy};
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_dispatch: got %h, expected no dispatch", gotPkt);
            end else begin
                wantPkt = expQ.pop_front();
                pktNum++;
                if (gotPkt !== wantPkt) begin
                    failures++;
                    $display("[TB] FAIL dispatch%0d: got cls=%b func=%h tag=%0d s1=%0d/%b s2=%0d/%b, expected cls=%b func=%h tag=%0d s1=%0d/%b s2=%0d/%b",
                             pktNum, gotPkt.cls, gotPkt.func, gotPkt.tag, gotPkt.s1Tag, gotPkt.s1Rdy,
                             gotPkt.s2Tag, gotPkt.s2Rdy, wantPkt.cls, wantPkt.func, wantPkt.tag,
                             wantPkt.s1Tag, wantPkt.s1Rdy, wantPkt.s2Tag, wantPkt.s2Rdy);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        driveIdle();
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_disp_valid", 32'(disp_valid), 32'd0);
        checkOutput("reset_disp_class", 32'(disp_class), 32'd0);
        checkOutput("reset_disp_tag", 32'(disp_tag), 32'd0);
        checkOutput("reset_rob_count", 32'(rob_count), 32'd0);
        checkOutput("reset_commit_tag", 32'(commit_tag), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // Dependency chain through r3 and CDB wakeup.
        issueOp(4'h0, 4'd1, 4'd2, 4'd3, 3'b001, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
        issueOp(4'h8, 4'd3, 4'd3, 4'd4, 3'b010, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        issueOp(4'h1, 4'd3, 4'd0, 4'd5, 3'b001, 3'd2, 3'd0, 3'd0, 1'b1, 1'b1);
        expQ.push_back('{cls: 3'b001, func: 4'h2, tag: 3'd3, s1Tag: 3'd1, s2Tag: 3'd0,
                         s1Rdy: BYPASS_RDY, s2Rdy: 1'b1});
        applyStimulus(1'b1, 4'h2, 4'd4, 4'd0, 4'd6, 1'b1, 3'd1, 1'b0, 1'b0);
        checkOutput("count_after_four", 32'(rob_count), 32'd4);
        checkOutput("head_after_four", 32'(commit_tag), 32'd0);
        issueOp(4'h0, 4'd0, 4'd0, 4'd8, 3'b001, 3'd4, 3'd0, 3'd0, 1'b1, 1'b1);

        // Flush with five outstanding; the offered instruction must not be taken.
        in_valid = 1'b1;
        in_rd    = 4'd9;
        flush    = 1'b1;
        #1;
        checkOutput("in_ready_during_flush", 32'(in_ready), 32'd0);
        @(negedge clk1);
        driveIdle();
        checkOutput("count_after_flush", 32'(rob_count), 32'd0);
        checkOutput("head_after_flush", 32'(commit_tag), 32'd0);
        issueOp(4'h0, 4'd3, 4'd4, 4'd1, 3'b001, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);

        // Two renames of r3; only the newest producer's commit frees it.
        applyStimulus(1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        issueOp(4'h0, 4'd0, 4'd0, 4'd3, 3'b001, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
        issueOp(4'h0, 4'd0, 4'd0, 4'd3, 3'b001, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1);
        checkOutput("head_before_commit0", 32'(commit_tag), 32'd0);
        applyStimulus(1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        issueOp(4'h0, 4'd3, 4'd0, 4'd9, 3'b001, 3'd2, 3'd1, 3'd0, 1'b0, 1'b1);
        checkOutput("head_before_commit1", 32'(commit_tag), 32'd1);
        applyStimulus(1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        issueOp(4'h0, 4'd3, 4'd0, 4'd10, 3'b001, 3'd3, 3'd0, 3'd0, 1'b1, 1'b1);
        checkOutput("count_after_commits", 32'(rob_count), 32'd2);
        checkOutput("head_after_commits", 32'(commit_tag), 32'd2);

        // Mul station busy: mul stalls, add and branch still issue; branch does not rename.
        rs_avail = 3'b101;
        in_valid = 1'b1;
        in_func  = 4'h8;
        in_rd    = 4'd11;
        #1;
        checkOutput("in_ready_mul_blocked", 32'(in_ready), 32'd0);
        @(negedge clk1);
        driveIdle();
        issueOp(4'h0, 4'd0, 4'd0, 4'd11, 3'b001, 3'd4, 3'd0, 3'd0, 1'b1, 1'b1);
        issueOp(4'hD, 4'd9, 4'd0, 4'd12, 3'b100, 3'd5, 3'd2, 3'd0, 1'b0, 1'b1);
        issueOp(4'h0, 4'd12, 4'd0, 4'd13, 3'b001, 3'd6, 3'd0, 3'd0, 1'b1, 1'b1);
        rs_avail = 3'b111;
        checkOutput("count_after_branch", 32'(rob_count), 32'd5);

        // Fill the ROB, then a commit frees a slot only from the next cycle on.
        applyStimulus(1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            issueOp(4'h0, 4'd0, 4'd0, 4'(i + 1), 3'b001, 3'(i), 3'd0, 3'd0, 1'b1, 1'b1);
        end
        checkOutput("count_full", 32'(rob_count), 32'd8);
        checkOutput("in_ready_full", 32'(in_ready), 32'd0);
        in_valid     = 1'b1;
        in_rs1       = 4'd2;
        in_rd        = 4'd9;
        commit_valid = 1'b1;
        #1;
        checkOutput("in_ready_commit_cycle", 32'(in_ready), 32'd0);
        @(negedge clk1);
        driveIdle();
        checkOutput("count_after_full_commit", 32'(rob_count), 32'd7);
        checkOutput("head_after_full_commit", 32'(commit_tag), 32'd1);
        checkOutput("in_ready_after_commit", 32'(in_ready), 32'd1);
        issueOp(4'h0, 4'd2, 4'd0, 4'd9, 3'b001, 3'd0, 3'd1, 3'd0, 1'b0, 1'b1);
        checkOutput("count_refull", 32'(rob_count), 32'd8);
        checkOutput("in_ready_refull", 32'(in_ready), 32'd0);

        // Asynchronous reset while a dispatch pulse is on the outputs.
        applyStimulus(1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_rd    = 4'd1;
        expQ.push_back('{cls: 3'b001, func: 4'h0, tag: 3'd0, s1Tag: 3'd0, s2Tag: 3'd0,
                         s1Rdy: 1'b1, s2Rdy: 1'b1});
        @(posedge clk1);
        #2;
        driveIdle();
        checkOutput("disp_valid_before_reset", 32'(disp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("disp_valid_async_reset", 32'(disp_valid), 32'd0);
        checkOutput("count_async_reset", 32'(rob_count), 32'd0);
        expQ.delete();
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        issueOp(4'h0, 4'd1, 4'd0, 4'd2, 3'b001, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
